// File: rtl/iob_pw_bridge.sv
// rtl/iob_pw_bridge.sv - CPU to asynchronous I/O bus bridge with posted-write FIFO
// Define IOB_TIMEOUT_EN to add a STRB watchdog of TOCYC cycles.
module iob_pw_bridge #(
  parameter int PWDEPTH = 2,
  parameter int TOCYC   = 255
) (
  input  logic        CLK,
  input  logic        nRES,
  input  logic        BACT,
  input  logic        IOCS,
  input  logic        IOPWCS,
  input  logic        nWE,
  input  logic [23:1] A,
  input  logic        nUDS,
  input  logic        nLDS,
  input  logic [15:0] D,
  output logic        nDTACKO,
  output logic [15:0] Q,
  output logic [23:1] IOA,
  output logic [15:0] IOD,
  output logic        IODOE,
  input  logic [15:0] IODI,
  output logic        nIOAS,
  output logic        nIOUDS,
  output logic        nIOLDS,
  output logic        IORnW,
  input  logic        nIODTACK,
  output logic        IOBUSY
);

  localparam int AW = (PWDEPTH > 1) ? $clog2(PWDEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ADDR, STRB, REL} state_t;

  typedef struct packed {
    logic [23:1] a;
    logic [15:0] d;
    logic        nuds;
    logic        nlds;
  } pw_t;

  state_t          state, state_nxt;
  pw_t             mem [PWDEPTH];
  pw_t             pend_e;
  logic [AW-1:0]   wp, rp;
  logic [CW-1:0]   cnt;
  logic            acc, pend, pend_rnw, live;
  logic            cur_posted, cur_nuds, cur_nlds;
  logic            dtk_s1, dtk;
  logic            full, push, pop, capture_dir;
  logic            load_fifo, load_dir, enter_rel, exit_rel;
  logic            to_hit, to_rel;

  // Fullness is judged on the pre-edge count, so a same-edge pop never admits a push.
  assign full        = (cnt == CW'(PWDEPTH));
  assign push        = BACT && IOPWCS && !nWE && !acc && !full;
  assign capture_dir = BACT && IOCS && !IOPWCS && !acc;
  assign load_fifo   = (state == IDLE) && (cnt != '0);
  assign load_dir    = (state == IDLE) && (cnt == '0) && pend && BACT;
  assign enter_rel   = (state == STRB) && (!dtk || to_hit);
  assign exit_rel    = (state == REL) && (dtk || to_rel);
  assign pop         = enter_rel && cur_posted;
  assign IOBUSY      = (cnt != '0) || (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load_fifo || load_dir) state_nxt = ADDR;
      ADDR:    state_nxt = STRB;
      STRB:    if (enter_rel) state_nxt = REL;
      REL:     if (exit_rel) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      state  <= IDLE;
      dtk_s1 <= 1'b1;
      dtk    <= 1'b1;
    end else begin
      state  <= state_nxt;
      dtk_s1 <= nIODTACK;
      dtk    <= dtk_s1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wp] <= {A, D, nUDS, nLDS};
  end

  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      if (push && !pop)      cnt <= cnt + CW'(1);
      else if (pop && !push) cnt <= cnt - CW'(1);
    end
  end

  // A falling BACT ends the CPU cycle: drops any pending request and any owed acknowledge.
  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      acc      <= 1'b0;
      pend     <= 1'b0;
      pend_rnw <= 1'b1;
      pend_e   <= '0;
      live     <= 1'b0;
      nDTACKO  <= 1'b1;
    end else if (!BACT) begin
      acc     <= 1'b0;
      pend    <= 1'b0;
      live    <= 1'b0;
      nDTACKO <= 1'b1;
    end else begin
      if (push || capture_dir) acc <= 1'b1;
      if (capture_dir) begin
        pend     <= 1'b1;
        pend_rnw <= nWE;
        pend_e   <= {A, D, nUDS, nLDS};
      end else if (load_dir) begin
        pend <= 1'b0;
      end
      if (load_dir) live <= 1'b1;
      if (push || (enter_rel && !cur_posted && live)) nDTACKO <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      IOA        <= '0;
      IOD        <= '0;
      IORnW      <= 1'b1;
      IODOE      <= 1'b0;
      nIOAS      <= 1'b1;
      nIOUDS     <= 1'b1;
      nIOLDS     <= 1'b1;
      Q          <= '0;
      cur_posted <= 1'b0;
      cur_nuds   <= 1'b1;
      cur_nlds   <= 1'b1;
    end else begin
      if (load_fifo) begin
        IOA        <= mem[rp].a;
        IOD        <= mem[rp].d;
        cur_nuds   <= mem[rp].nuds;
        cur_nlds   <= mem[rp].nlds;
        IORnW      <= 1'b0;
        IODOE      <= 1'b1;
        cur_posted <= 1'b1;
      end else if (load_dir) begin
        IOA        <= pend_e.a;
        IOD        <= pend_e.d;
        cur_nuds   <= pend_e.nuds;
        cur_nlds   <= pend_e.nlds;
        IORnW      <= pend_rnw;
        IODOE      <= !pend_rnw;
        cur_posted <= 1'b0;
      end
      if (state == ADDR) begin
        nIOAS  <= 1'b0;
        nIOUDS <= cur_nuds;
        nIOLDS <= cur_nlds;
      end
      if (enter_rel) begin
        nIOAS  <= 1'b1;
        nIOUDS <= 1'b1;
        nIOLDS <= 1'b1;
        IODOE  <= 1'b0;
        if (IORnW) Q <= (to_hit && dtk) ? 16'hFFFF : IODI;
      end
      if (exit_rel) IORnW <= 1'b1;
    end
  end

`ifdef IOB_TIMEOUT_EN
  localparam int TW = $clog2(TOCYC + 1);
  logic [TW-1:0] to_cnt;
  logic          to_fired;

  assign to_hit = (state == STRB) && (to_cnt == TW'(TOCYC - 1));
  assign to_rel = to_fired;

  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      to_cnt   <= '0;
      to_fired <= 1'b0;
    end else begin
      if (state != STRB)  to_cnt <= '0;
      else if (!to_hit)   to_cnt <= to_cnt + TW'(1);
      if (enter_rel) to_fired <= to_hit && dtk;
    end
  end
`else
  assign to_hit = 1'b0;
  assign to_rel = 1'b0;
`endif

endmodule

// File: tb/tb_iob_pw_bridge.sv
// tb/tb_iob_pw_bridge.sv - directed bench with a transaction-level I/O bus model
module tb_iob_pw_bridge;
  localparam int TOCYC = 16;

  logic        CLK = 1'b0, nRES = 1'b0;
  logic        BACT = 1'b0, IOCS = 1'b0, IOPWCS = 1'b0, nWE = 1'b1;
  logic        nUDS = 1'b1, nLDS = 1'b1, nIODTACK = 1'b1;
  logic [23:1] A = '0;
  logic [15:0] D = '0, IODI = '0;
  logic        nDTACKO, IODOE, nIOAS, nIOUDS, nIOLDS, IORnW, IOBUSY;
  logic [15:0] Q, IOD;
  logic [23:1] IOA;

  int nvec = 0, nmis = 0;
  bit ack_en = 1'b1;
  logic prev_as = 1'b1;

  typedef struct packed {
    logic [23:1] a;
    logic [15:0] d;
    logic        rnw;
    logic        nuds;
    logic        nlds;
  } io_t;
  io_t exp_q[$];

  iob_pw_bridge #(.PWDEPTH(2), .TOCYC(TOCYC)) dut (
    .CLK(CLK), .nRES(nRES), .BACT(BACT), .IOCS(IOCS), .IOPWCS(IOPWCS), .nWE(nWE),
    .A(A), .nUDS(nUDS), .nLDS(nLDS), .D(D), .nDTACKO(nDTACKO), .Q(Q), .IOA(IOA),
    .IOD(IOD), .IODOE(IODOE), .IODI(IODI), .nIOAS(nIOAS), .nIOUDS(nIOUDS),
    .nIOLDS(nIOLDS), .IORnW(IORnW), .nIODTACK(nIODTACK), .IOBUSY(IOBUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // I/O device: acknowledges by mirroring the address strobe one step after each edge.
  always begin
    @(posedge CLK);
    #1;
    if (ack_en) nIODTACK = nIOAS;
  end

  // Every strobed bus cycle must match the oldest outstanding expected transfer.
  always @(negedge CLK) begin
    if (nRES && !nIOAS) begin
      if (exp_q.size() == 0) begin
        nvec++;
        nmis++;
        $display("FAIL unexpected_io: got IOA %0h expected no cycle", IOA);
      end else begin
        chk("io_addr", 32'(IOA), 32'(exp_q[0].a));
        chk("io_rnw", 32'(IORnW), 32'(exp_q[0].rnw));
        chk("io_uds", 32'(nIOUDS), 32'(exp_q[0].nuds));
        chk("io_lds", 32'(nIOLDS), 32'(exp_q[0].nlds));
        chk("io_busy", 32'(IOBUSY), 32'd1);
        chk("io_doe", 32'(IODOE), 32'(!exp_q[0].rnw));
        if (!exp_q[0].rnw) chk("io_data", 32'(IOD), 32'(exp_q[0].d));
      end
    end else if (!prev_as && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end
    prev_as = nIOAS;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic bact, iocs, pwcs, nwe, input logic [23:1] a,
                       input logic [15:0] d, input logic uds, lds);
    BACT = bact; IOCS = iocs; IOPWCS = pwcs; nWE = nwe;
    A = a; D = d; nUDS = uds; nLDS = lds;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b1, A, D, 1'b1, 1'b1);
  endtask

  // Returns the number of rising edges from request drive until nDTACKO is seen low.
  task automatic wait_ack(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (nDTACKO !== 1'b0 && n < 80);
    if (nDTACKO !== 1'b0) n = -1;
  endtask

  task automatic wait_as(input logic lvl, output int n);
    n = 0;
    while (nIOAS !== lvl && n < 60) begin
      step();
      n++;
    end
    if (nIOAS !== lvl) n = -1;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((IOBUSY !== 1'b0 || nIOAS !== 1'b1) && k < 100) begin
      step();
      k++;
    end
    chk({name, "_busy"}, 32'(IOBUSY), 32'd0);
    chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pw(input string name, input logic [23:1] a, input logic [15:0] d,
                    input logic uds, lds);
    int n;
    exp_q.push_back({a, d, 1'b0, uds, lds});
    drive(1'b1, 1'b1, 1'b1, 1'b0, a, d, uds, lds);
    wait_ack(n);
    chk({name, "_lat"}, 32'(n), 32'd1);
    idle();
    step();
    chk({name, "_release"}, 32'(nDTACKO), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, k;
    bit saw;

    repeat (3) step();
    chk("rst_dtack", 32'(nDTACKO), 32'd1);
    chk("rst_as", 32'(nIOAS), 32'd1);
    chk("rst_uds", 32'(nIOUDS), 32'd1);
    chk("rst_lds", 32'(nIOLDS), 32'd1);
    chk("rst_rnw", 32'(IORnW), 32'd1);
    chk("rst_doe", 32'(IODOE), 32'd0);
    chk("rst_q", 32'(Q), 32'd0);
    chk("rst_ioa", 32'(IOA), 32'd0);
    chk("rst_iod", 32'(IOD), 32'd0);
    chk("rst_busy", 32'(IOBUSY), 32'd0);
    nRES = 1'b1;
    step();

    // Byte address 0x3FA100 appears on A[23:1] as 0x1FD080.
    pw("t1", 23'h1FD080, 16'h1234, 1'b0, 1'b0);
    wait_as(1'b0, n);
    chk("t1_ioa", 32'(IOA), 32'h1FD080);
    chk("t1_iod", 32'(IOD), 32'h1234);
    chk("t1_strobes", 32'({nIOUDS, nIOLDS}), 32'd0);
    wait_idle("t1");

    ack_en = 1'b0;
    nIODTACK = 1'b1;
    pw("t2_w1", 23'h000010, 16'h1111, 1'b0, 1'b0);
    pw("t2_w2", 23'h000011, 16'h2222, 1'b0, 1'b0);
    exp_q.push_back({23'h000012, 16'h3333, 1'b0, 1'b0, 1'b0});
    drive(1'b1, 1'b1, 1'b1, 1'b0, 23'h000012, 16'h3333, 1'b0, 1'b0);
    repeat (6) begin
      step();
      chk("t2_w3_stall", 32'(nDTACKO), 32'd1);
    end
    ack_en = 1'b1;
    wait_as(1'b1, n);
    chk("t2_rel_seen", 32'(nIOAS), 32'd1);
    chk("t2_w3_at_rel", 32'(nDTACKO), 32'd1);
    step();
    chk("t2_w3_ack", 32'(nDTACKO), 32'd0);
    idle();
    step();
    wait_idle("t2");

    IODI = 16'hA5A5;
    pw("t3_pw", 23'h000100, 16'hBEEF, 1'b0, 1'b0);
    exp_q.push_back({23'h77F0FF, 16'h0000, 1'b1, 1'b0, 1'b0});
    drive(1'b1, 1'b1, 1'b0, 1'b1, 23'h77F0FF, 16'h0000, 1'b0, 1'b0);
    wait_ack(n);
    chk("t3_lat", 32'(n), 32'd12);
    chk("t3_q", 32'(Q), 32'hA5A5);
    step();
    chk("t3_ack_hold", 32'(nDTACKO), 32'd0);
    idle();
    step();
    chk("t3_release", 32'(nDTACKO), 32'd1);
    chk("t3_q_stable", 32'(Q), 32'hA5A5);
    wait_idle("t3");

    // Direct read, empty FIFO: sample edge then pending, ADDR, STRB, sync x2, REL.
    IODI = 16'h5A3C;
    exp_q.push_back({23'h012345, 16'h0000, 1'b1, 1'b0, 1'b0});
    drive(1'b1, 1'b1, 1'b0, 1'b1, 23'h012345, 16'h0000, 1'b0, 1'b0);
    wait_ack(n);
    chk("t4_lat", 32'(n), 32'd6);
    chk("t4_q", 32'(Q), 32'h5A3C);
    idle();
    step();
    wait_idle("t4");

    exp_q.push_back({23'h000ABC, 16'h00C3, 1'b0, 1'b1, 1'b0});
    drive(1'b1, 1'b1, 1'b0, 1'b0, 23'h000ABC, 16'h00C3, 1'b1, 1'b0);
    wait_ack(n);
    chk("t5_lat", 32'(n), 32'd6);
    chk("t5_q_hold", 32'(Q), 32'h5A3C);
    idle();
    step();
    wait_idle("t5");

    ack_en = 1'b0;
    nIODTACK = 1'b1;
    pw("t6_pw", 23'h000200, 16'h0F0F, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 23'h033333, 16'h0000, 1'b0, 1'b0);
    repeat (2) begin
      step();
      chk("t6_no_ack", 32'(nDTACKO), 32'd1);
    end
    idle();
    step();
    ack_en = 1'b1;
    wait_idle("t6");

    ack_en = 1'b0;
    nIODTACK = 1'b1;
    IODI = 16'h1111;
    exp_q.push_back({23'h055555, 16'h0000, 1'b1, 1'b0, 1'b0});
    drive(1'b1, 1'b1, 1'b0, 1'b1, 23'h055555, 16'h0000, 1'b0, 1'b0);
    wait_as(1'b0, n);
    chk("t7_started", 32'(nIOAS), 32'd0);
    idle();
    ack_en = 1'b1;
    saw = 1'b0;
    k = 0;
    while ((IOBUSY !== 1'b0 || nIOAS !== 1'b1) && k < 100) begin
      step();
      k++;
      if (nDTACKO === 1'b0) saw = 1'b1;
    end
    chk("t7_no_late_ack", 32'(saw), 32'd0);
    wait_idle("t7");

    ack_en = 1'b0;
    nIODTACK = 1'b1;
    pw("t8_pw", 23'h0000AA, 16'h5555, 1'b0, 1'b0);
    wait_as(1'b0, n);
    #3;
    nRES = 1'b0;
    #1;
    exp_q.delete();
    chk("t8_as", 32'(nIOAS), 32'd1);
    chk("t8_uds", 32'(nIOUDS), 32'd1);
    chk("t8_lds", 32'(nIOLDS), 32'd1);
    chk("t8_dtack", 32'(nDTACKO), 32'd1);
    chk("t8_doe", 32'(IODOE), 32'd0);
    chk("t8_busy_rst", 32'(IOBUSY), 32'd0);
    step();
    nRES = 1'b1;
    ack_en = 1'b1;
    step();
    step();
    chk("t8_busy_after", 32'(IOBUSY), 32'd0);
    chk("t8_as_after", 32'(nIOAS), 32'd1);

`ifdef IOB_TIMEOUT_EN
    ack_en = 1'b0;
    nIODTACK = 1'b1;
    exp_q.push_back({23'h077777, 16'h0000, 1'b1, 1'b0, 1'b0});
    drive(1'b1, 1'b1, 1'b0, 1'b1, 23'h077777, 16'h0000, 1'b0, 1'b0);
    wait_as(1'b0, n);
    wait_as(1'b1, k);
    chk("t9_strb_cycles", 32'(k), 32'd16);
    chk("t9_dtack", 32'(nDTACKO), 32'd0);
    chk("t9_q", 32'(Q), 32'hFFFF);
    idle();
    step();
    wait_idle("t9");
    ack_en = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/iob_pw_bridge.md
# iob_pw_bridge

Bridges CPU bus cycles that the chip-select decoder routes to the I/O-bus domain (IOCS) onto the slow asynchronous 68000-style I/O bus, and returns cycle termination to the CPU. Posted writes (IOPWCS, video/sound RAM writes) are acknowledged immediately and drained from a small FIFO. All other I/O cycles (reads, non-posted writes) are issued after the FIFO drains and are acknowledged only when the I/O bus completes. It sits between the CPU-side decoder and the I/O-bus pins.

## Interface
- PWDEPTH, 2: posted-write FIFO depth; power of two, 2..8.
- TOCYC, 255: watchdog limit in CLK cycles; used only with IOB_TIMEOUT_EN.

- CLK  in  1  system clock; all state on rising edge.
- nRES  in  1  reset; asynchronous, active-low.
- BACT  in  1  CPU bus cycle active, from AS detection.
- IOCS, IOPWCS  in  1 each  decoder selects; IOPWCS implies IOCS.
- nWE  in  1  CPU write (0 = write).
- A  in  23  CPU address A[23:1].
- nUDS, nLDS  in  1 each  CPU byte strobes.
- D  in  16  CPU write data.
- nDTACKO  out  1  CPU cycle termination, active-low.
- Q  out  16  read data to CPU, valid while nDTACKO=0.
- IOA  out  23  I/O-bus address.
- IOD  out  16  I/O-bus write data; IODOE  out  1  data drive enable.
- IODI  in  16  I/O-bus read data.
- nIOAS, nIOUDS, nIOLDS  out  1 each  I/O-bus strobes.
- IORnW  out  1  I/O-bus direction (1 = read).
- nIODTACK  in  1  asynchronous I/O-bus acknowledge.
- IOBUSY  out  1  FIFO non-empty or I/O FSM not IDLE.

## Operation
- Request capture: an `acc` flag is set on the first edge where BACT=1 and the request is accepted. It clears on the first edge where BACT=0. At most one acceptance occurs per BACT assertion.
- Posted write (BACT & IOPWCS & !nWE & !acc):
  - If the FIFO is not full before the edge, push {A, D, nUDS, nLDS}, set acc, and drive nDTACKO=0.
  - If the FIFO is full, stall (no push, no acknowledge) until a slot frees.
- Direct cycle (BACT & IOCS & !IOPWCS & !acc): latch a pending request. It is issued only when the FIFO is empty and the FSM is IDLE, which preserves ordering behind posted writes.
- nDTACKO stays low until the edge after BACT falls, then returns high.
- nIODTACK passes through a 2-flop synchronizer to give `dtk`.
- I/O FSM states:
  - IDLE: if the FIFO is non-empty, load the head entry and go to ADDR. Otherwise, if a direct request is pending, load it and go to ADDR. FIFO has priority.
  - ADDR: drive IOA and IORnW; IODOE=1 for writes. Strobes stay high. Next edge goes to STRB.
  - STRB: nIOAS=0; nIOUDS and nIOLDS follow the entry's mask. When `dtk`=0, go to REL.
  - REL (on entry): capture IODI into Q for reads; pop the FIFO if the cycle is posted; for direct cycles, set nDTACKO=0. Strobes go high, IODOE=0. Return to IDLE when `dtk`=1.
- Boundary behaviour:
  - Full FIFO plus a pop on the same edge: the push is still refused that edge (fullness is judged before the edge).
  - Push and pop on the same edge leave the count unchanged.
  - If BACT drops before a direct cycle leaves IDLE, the pending request is dropped.
  - If BACT drops once a direct cycle has started, the I/O cycle completes but no nDTACKO is issued.
- Reset values: nDTACKO=1, nIOAS=nIOUDS=nIOLDS=1, IORnW=1, IODOE=0, Q=0, IOA=0, IOD=0, FIFO empty, FSM=IDLE, acc=0, IOBUSY=0. Asserting reset mid-cycle releases the strobes immediately (asynchronously).

## Timing
- Posted-write acknowledge: nDTACKO low 1 edge after the qualifying BACT sample.
- Minimum I/O cycle from IDLE: ADDR 1 cycle, STRB of at least 1 cycle plus 2 synchronizer cycles after nIODTACK falls, REL of at least 2 cycles plus 2 synchronizer cycles after nIODTACK rises.
- Direct read with empty FIFO and immediate nIODTACK: nDTACKO low 5 edges after the BACT sample (pending, ADDR, STRB, sync×2, REL).
- Q is stable from the REL entry edge until the next read's REL.

## Configuration
- IOB_TIMEOUT_EN defined:
  - A counter runs in STRB.
  - After TOCYC cycles without `dtk`=0, force REL; for reads, Q=16'hFFFF.
  - REL then exits without waiting for `dtk`=1.
- Undefined: STRB waits indefinitely; no counter logic is present.

## Test plan
- Posted write A=0x3FA100, D=0x1234, nUDS=nLDS=0, FIFO empty -> nDTACKO low 1 edge later; one I/O write to IOA=0x3FA100/2 with IOD=0x1234 and both strobes low.
- Three back-to-back posted writes, PWDEPTH=2, nIODTACK held high -> first two acknowledged; third stalls with nDTACKO=1 until the first I/O cycle reaches REL, then acknowledges the following edge.
- Posted write then read A=0xEFE1FE with IODI=0xA5A5 -> the read's nIOAS is not asserted until the write's REL completes; Q=0xA5A5 with nDTACKO=0.
- nRES asserted during STRB -> strobes and nDTACKO high with no clock edge; FIFO empty; IOBUSY=0 after release.
- With IOB_TIMEOUT_EN and TOCYC=16, read with nIODTACK stuck high -> REL after 16 STRB cycles; Q=0xFFFF; nDTACKO=0.
- Byte write with nUDS=1, nLDS=0 -> nIOUDS stays 1 and nIOLDS=0 throughout STRB.
